ysyx_22040895_csrfile: RTL and testbench

Machine-mode CSR register file for the ysyx_22040895 RV64 core: the responder on the execute unit's CSR/trap interface. It serves combinational reads of the addressed CSR and the dedicated trap CSRs (mepc, mcause, mtvec, mstatus). It commits csrrw/csrrs, ecall and mret side effects on the clock edge, and maintains free-running mcycle and minstret counters. It sits beside the register file and is written only when the execute-stage instruction commits.

---
 rtl/ysyx_22040895_csrfile_if.sv | 32 +++
 rtl/ysyx_22040895_csrfile.sv | 221 ++++++++++++++++++++++
 tb/tb_ysyx_22040895_csrfile.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22040895_csrfile_if.sv
// CSR/trap interface between the execute unit (master) and the
// machine-mode CSR file (slave). The _i/_o suffixes follow the CSR
// file's point of view.
interface ysyx_22040895_csrfile_if;
    logic        commit_i_csr;
    logic [2:0]  privileged_op_i_csr;
    logic [11:0] csr_addr_i_csr;
    logic [63:0] csrwdata_i_csr;
    logic [63:0] wdata_mepc_i_csr;
    logic [63:0] wdata_mcause_i_csr;
    logic [63:0] wdata_mstatus_i_csr;
    logic [63:0] csrrdata_o_csr;
    logic [63:0] rdata_mepc_o_csr;
    logic [63:0] rdata_mcause_o_csr;
    logic [63:0] rdata_mtvec_o_csr;
    logic [63:0] rdata_mstatus_o_csr;
    logic        illegal_o_csr;

    modport master (
        output commit_i_csr, privileged_op_i_csr, csr_addr_i_csr, csrwdata_i_csr,
               wdata_mepc_i_csr, wdata_mcause_i_csr, wdata_mstatus_i_csr,
        input  csrrdata_o_csr, rdata_mepc_o_csr, rdata_mcause_o_csr,
               rdata_mtvec_o_csr, rdata_mstatus_o_csr, illegal_o_csr
    );

    modport slave (
        input  commit_i_csr, privileged_op_i_csr, csr_addr_i_csr, csrwdata_i_csr,
               wdata_mepc_i_csr, wdata_mcause_i_csr, wdata_mstatus_i_csr,
        output csrrdata_o_csr, rdata_mepc_o_csr, rdata_mcause_o_csr,
               rdata_mtvec_o_csr, rdata_mstatus_o_csr, illegal_o_csr
    );
endinterface

// File: rtl/ysyx_22040895_csrfile.sv
// Machine-mode CSR file for the ysyx_22040895 RV64 core.
// Reads are combinational from current register state (no write bypass);
// architectural writes happen on the edge where the execute-stage
// instruction commits. mcycle free-runs, minstret counts commits.
module ysyx_22040895_csrfile (
    input  logic                          clk,
    input  logic                          rst,
    ysyx_22040895_csrfile_if.slave        csr_bus
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MISA     = 12'h301;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
    localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

    localparam logic [2:0] OP_ECALL = 3'b001;
    localparam logic [2:0] OP_MRET  = 3'b010;
    localparam logic [2:0] OP_CSRRS = 3'b011;
    localparam logic [2:0] OP_CSRRW = 3'b100;

    localparam logic [63:0] MSTATUS_RST = 64'h0000_000A_0000_1800;
    localparam logic [63:0] MISA_VAL    = 64'h8000_0000_0000_1100;
    localparam logic [63:0] MHARTID_VAL = 64'h0000_0000_0000_0000;

    // SXL/UXL are hardwired to 64-bit (4'hA); everything else passes through.
    function automatic logic [63:0] mask_mstatus(input logic [63:0] value);
        mask_mstatus = {value[63:36], 4'hA, value[31:0]};
    endfunction

    // mtvec and mepc are always 4-byte aligned.
    function automatic logic [63:0] mask_align(input logic [63:0] value);
        mask_align = {value[63:2], 2'b00};
    endfunction

    // Trap entry: stash MIE in MPIE, disable interrupts, record M-mode as MPP.
    function automatic logic [63:0] ecall_mstatus(input logic [63:0] value);
        logic [63:0] tmp;
        tmp        = value;
        tmp[7]     = value[3];
        tmp[3]     = 1'b0;
        tmp[12:11] = 2'b11;
        ecall_mstatus = mask_mstatus(tmp);
    endfunction

    logic [63:0] mstatus_r, mtvec_r, mscratch_r, mepc_r, mcause_r, mcycle_r, minstret_r;
    logic [63:0] mstatus_nxt_s, mtvec_nxt_s, mscratch_nxt_s, mepc_nxt_s, mcause_nxt_s;
    logic [63:0] mcycle_nxt_s, minstret_nxt_s;

    logic        op_ecall_s, op_mret_s, op_csr_s, op_csrrw_s;
    logic        implemented_s, read_only_s;
    logic [63:0] rdata_s;
    logic        wr_en_s;
    logic        commit_ecall_s, commit_mret_s;

    // Decode the privileged op; reserved encodings behave as no-op.
    always_comb begin
        op_ecall_s = 1'b0;
        op_mret_s  = 1'b0;
        op_csr_s   = 1'b0;
        op_csrrw_s = 1'b0;
        case (csr_bus.privileged_op_i_csr)
            OP_ECALL: op_ecall_s = 1'b1;
            OP_MRET:  op_mret_s  = 1'b1;
            OP_CSRRS: op_csr_s   = 1'b1;
            OP_CSRRW: begin
                op_csr_s   = 1'b1;
                op_csrrw_s = 1'b1;
            end
            default: begin
                op_ecall_s = 1'b0;
                op_mret_s  = 1'b0;
                op_csr_s   = 1'b0;
                op_csrrw_s = 1'b0;
            end
        endcase
    end

    // Address decode: read mux plus implemented/read-only classification.
    always_comb begin
        implemented_s = 1'b1;
        read_only_s   = 1'b0;
        rdata_s       = 64'h0;
        case (csr_bus.csr_addr_i_csr)
            ADDR_MSTATUS:  rdata_s = mstatus_r;
            ADDR_MISA: begin
                rdata_s     = MISA_VAL;
                read_only_s = 1'b1;
            end
            ADDR_MTVEC:    rdata_s = mtvec_r;
            ADDR_MSCRATCH: rdata_s = mscratch_r;
            ADDR_MEPC:     rdata_s = mepc_r;
            ADDR_MCAUSE:   rdata_s = mcause_r;
            ADDR_MCYCLE:   rdata_s = mcycle_r;
            ADDR_MINSTRET: rdata_s = minstret_r;
            ADDR_MHARTID: begin
                rdata_s     = MHARTID_VAL;
                read_only_s = 1'b1;
            end
            default: begin
                rdata_s       = 64'h0;
                implemented_s = 1'b0;
            end
        endcase
    end

    // Write qualification; illegal flags are independent of commit.
    always_comb begin
        wr_en_s        = csr_bus.commit_i_csr & op_csr_s & implemented_s & ~read_only_s;
        commit_ecall_s = csr_bus.commit_i_csr & op_ecall_s;
        commit_mret_s  = csr_bus.commit_i_csr & op_mret_s;
        if (op_csr_s) begin
            csr_bus.illegal_o_csr = ~implemented_s | (op_csrrw_s & read_only_s);
        end else begin
            csr_bus.illegal_o_csr = 1'b0;
        end
    end

    // Next mstatus: CSR write, trap entry or trap return (mutually exclusive ops).
    always_comb begin
        mstatus_nxt_s = mstatus_r;
        if (wr_en_s && (csr_bus.csr_addr_i_csr == ADDR_MSTATUS)) begin
            mstatus_nxt_s = mask_mstatus(csr_bus.csrwdata_i_csr);
        end else if (commit_ecall_s) begin
            mstatus_nxt_s = ecall_mstatus(mstatus_r);
        end else if (commit_mret_s) begin
            mstatus_nxt_s = mask_mstatus(csr_bus.wdata_mstatus_i_csr);
        end else begin
            mstatus_nxt_s = mstatus_r;
        end
    end

    // Next mtvec/mscratch: only written through csrrs/csrrw.
    always_comb begin
        mtvec_nxt_s    = mtvec_r;
        mscratch_nxt_s = mscratch_r;
        if (wr_en_s && (csr_bus.csr_addr_i_csr == ADDR_MTVEC)) begin
            mtvec_nxt_s = mask_align(csr_bus.csrwdata_i_csr);
        end else begin
            mtvec_nxt_s = mtvec_r;
        end
        if (wr_en_s && (csr_bus.csr_addr_i_csr == ADDR_MSCRATCH)) begin
            mscratch_nxt_s = csr_bus.csrwdata_i_csr;
        end else begin
            mscratch_nxt_s = mscratch_r;
        end
    end

    // Next mepc/mcause: CSR write or trap entry.
    always_comb begin
        mepc_nxt_s   = mepc_r;
        mcause_nxt_s = mcause_r;
        if (wr_en_s && (csr_bus.csr_addr_i_csr == ADDR_MEPC)) begin
            mepc_nxt_s = mask_align(csr_bus.csrwdata_i_csr);
        end else if (commit_ecall_s) begin
            mepc_nxt_s = mask_align(csr_bus.wdata_mepc_i_csr);
        end else begin
            mepc_nxt_s = mepc_r;
        end
        if (wr_en_s && (csr_bus.csr_addr_i_csr == ADDR_MCAUSE)) begin
            mcause_nxt_s = csr_bus.csrwdata_i_csr;
        end else if (commit_ecall_s) begin
            mcause_nxt_s = csr_bus.wdata_mcause_i_csr;
        end else begin
            mcause_nxt_s = mcause_r;
        end
    end

    // Next counters: an explicit write beats the increment; both wrap naturally.
    always_comb begin
        mcycle_nxt_s   = mcycle_r + 64'd1;
        minstret_nxt_s = minstret_r;
        if (wr_en_s && (csr_bus.csr_addr_i_csr == ADDR_MCYCLE)) begin
            mcycle_nxt_s = csr_bus.csrwdata_i_csr;
        end else begin
            mcycle_nxt_s = mcycle_r + 64'd1;
        end
        if (wr_en_s && (csr_bus.csr_addr_i_csr == ADDR_MINSTRET)) begin
            minstret_nxt_s = csr_bus.csrwdata_i_csr;
        end else if (csr_bus.commit_i_csr) begin
            minstret_nxt_s = minstret_r + 64'd1;
        end else begin
            minstret_nxt_s = minstret_r;
        end
    end

    // Architectural state registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_r  <= MSTATUS_RST;
            mtvec_r    <= 64'h0;
            mscratch_r <= 64'h0;
            mepc_r     <= 64'h0;
            mcause_r   <= 64'h0;
            mcycle_r   <= 64'h0;
            minstret_r <= 64'h0;
        end else begin
            mstatus_r  <= mstatus_nxt_s;
            mtvec_r    <= mtvec_nxt_s;
            mscratch_r <= mscratch_nxt_s;
            mepc_r     <= mepc_nxt_s;
            mcause_r   <= mcause_nxt_s;
            mcycle_r   <= mcycle_nxt_s;
            minstret_r <= minstret_nxt_s;
        end
    end

    // Drive read ports straight from register state.
    always_comb begin
        csr_bus.csrrdata_o_csr      = rdata_s;
        csr_bus.rdata_mepc_o_csr    = mepc_r;
        csr_bus.rdata_mcause_o_csr  = mcause_r;
        csr_bus.rdata_mtvec_o_csr   = mtvec_r;
        csr_bus.rdata_mstatus_o_csr = mstatus_r;
    end

endmodule

// File: tb/tb_ysyx_22040895_csrfile.sv
// Directed bench for the machine-mode CSR file.
module tb_ysyx_22040895_csrfile;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ysyx_22040895_csrfile_if bus ();

    ysyx_22040895_csrfile dut (
        .clk     (clk),
        .rst     (rst),
        .csr_bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [11:0] addr, input logic [63:0] exp);
        bus.csr_addr_i_csr = addr;
        #1;
        chk(tag, bus.csrrdata_o_csr, exp);
    endtask

    task automatic idle();
        bus.commit_i_csr        = 1'b0;
        bus.privileged_op_i_csr = 3'b000;
        bus.csr_addr_i_csr      = 12'h000;
        bus.csrwdata_i_csr      = 64'h0;
        bus.wdata_mepc_i_csr    = 64'h0;
        bus.wdata_mcause_i_csr  = 64'h0;
        bus.wdata_mstatus_i_csr = 64'h0;
    endtask

    task automatic drive(input logic commit, input logic [2:0] op,
                         input logic [11:0] addr, input logic [63:0] wdata);
        bus.commit_i_csr        = commit;
        bus.privileged_op_i_csr = op;
        bus.csr_addr_i_csr      = addr;
        bus.csrwdata_i_csr      = wdata;
    endtask

    // Let one posedge happen, then return on the following negedge with inputs idle.
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle();
        @(negedge clk);

        // Reset values on every implemented address
        rd("rst_mstatus",  12'h300, 64'h0000_000A_0000_1800);
        rd("rst_misa",     12'h301, 64'h8000_0000_0000_1100);
        rd("rst_mtvec",    12'h305, 64'h0);
        rd("rst_mscratch", 12'h340, 64'h0);
        rd("rst_mepc",     12'h341, 64'h0);
        rd("rst_mcause",   12'h342, 64'h0);
        rd("rst_mcycle",   12'hB00, 64'h0);
        rd("rst_minstret", 12'hB02, 64'h0);
        rd("rst_mhartid",  12'hF14, 64'h0);
        rd("rst_unimpl",   12'h7C0, 64'h0);
        chk("rst_illegal_noop", {63'd0, bus.illegal_o_csr}, 64'd0);
        chk("rst_port_mstatus", bus.rdata_mstatus_o_csr, 64'h0000_000A_0000_1800);

        // Release reset and idle ten edges
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rd("idle_mcycle", 12'hB00, 64'd10);
        rd("idle_minstret", 12'hB02, 64'd0);

        // csrrw mtvec, low bits masked
        drive(1'b1, 3'b100, 12'h305, 64'h8000_0007);
        #1;
        chk("mtvec_wr_illegal", {63'd0, bus.illegal_o_csr}, 64'd0);
        chk("mtvec_no_bypass", bus.rdata_mtvec_o_csr, 64'h0);
        cycle();
        chk("mtvec_written", bus.rdata_mtvec_o_csr, 64'h8000_0004);
        rd("minstret_one", 12'hB02, 64'd1);

        // Same op without commit: nothing changes
        drive(1'b0, 3'b100, 12'h305, 64'h1234_5678);
        cycle();
        chk("mtvec_nocommit", bus.rdata_mtvec_o_csr, 64'h8000_0004);
        rd("minstret_nocommit", 12'hB02, 64'd1);

        // mstatus write with MIE set; SXL/UXL forced back to A
        drive(1'b1, 3'b100, 12'h300, 64'h0000_0005_0000_1808);
        cycle();
        chk("mstatus_masked", bus.rdata_mstatus_o_csr, 64'h0000_000A_0000_1808);

        // ecall
        drive(1'b1, 3'b001, 12'h000, 64'h0);
        bus.wdata_mepc_i_csr   = 64'h8000_0100;
        bus.wdata_mcause_i_csr = 64'd11;
        cycle();
        chk("ecall_mepc", bus.rdata_mepc_o_csr, 64'h8000_0100);
        chk("ecall_mcause", bus.rdata_mcause_o_csr, 64'd11);
        chk("ecall_mie", {63'd0, bus.rdata_mstatus_o_csr[3]}, 64'd0);
        chk("ecall_mpie", {63'd0, bus.rdata_mstatus_o_csr[7]}, 64'd1);
        chk("ecall_mpp", {62'd0, bus.rdata_mstatus_o_csr[12:11]}, 64'd3);
        chk("ecall_mstatus", bus.rdata_mstatus_o_csr, 64'h0000_000A_0000_1880);

        // mret
        drive(1'b1, 3'b010, 12'h000, 64'h0);
        bus.wdata_mstatus_i_csr = 64'h0000_0000_0000_0088;
        cycle();
        chk("mret_mstatus", bus.rdata_mstatus_o_csr, 64'h0000_000A_0000_0088);

        // Illegal accesses
        drive(1'b1, 3'b100, 12'hF14, 64'd5);
        #1;
        chk("csrrw_ro_illegal", {63'd0, bus.illegal_o_csr}, 64'd1);
        cycle();
        rd("mhartid_kept", 12'hF14, 64'h0);
        drive(1'b0, 3'b011, 12'h7C0, 64'd1);
        #1;
        chk("csrrs_unimpl_illegal", {63'd0, bus.illegal_o_csr}, 64'd1);
        drive(1'b1, 3'b011, 12'h301, 64'hFFFF);
        #1;
        chk("csrrs_ro_legal", {63'd0, bus.illegal_o_csr}, 64'd0);
        cycle();
        rd("misa_kept", 12'h301, 64'h8000_0000_0000_1100);

        // mcycle write wins over increment, then wraps
        drive(1'b1, 3'b100, 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        rd("mcycle_written", 12'hB00, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        rd("mcycle_wrap", 12'hB00, 64'h0);

        // minstret write wins over the commit increment
        drive(1'b1, 3'b100, 12'hB02, 64'h1234);
        cycle();
        rd("minstret_written", 12'hB02, 64'h1234);
        drive(1'b1, 3'b000, 12'h000, 64'h0);
        cycle();
        rd("minstret_inc", 12'hB02, 64'h1235);

        // mepc alignment and full-width mscratch
        drive(1'b1, 3'b100, 12'h341, 64'h8000_0207);
        cycle();
        chk("mepc_masked", bus.rdata_mepc_o_csr, 64'h8000_0204);
        drive(1'b1, 3'b011, 12'h340, 64'hDEAD_BEEF_CAFE_F00D);
        cycle();
        rd("mscratch_written", 12'h340, 64'hDEAD_BEEF_CAFE_F00D);

        // Asynchronous reset between edges
        bus.csr_addr_i_csr = 12'hB02;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_minstret", bus.csrrdata_o_csr, 64'h0);
        chk("arst_mstatus", bus.rdata_mstatus_o_csr, 64'h0000_000A_0000_1800);
        chk("arst_mtvec", bus.rdata_mtvec_o_csr, 64'h0);
        chk("arst_mepc", bus.rdata_mepc_o_csr, 64'h0);
        chk("arst_mcause", bus.rdata_mcause_o_csr, 64'h0);
        rd("arst_mscratch", 12'h340, 64'h0);
        rd("arst_mcycle", 12'hB00, 64'h0);

        // First posedge after release gives mcycle=1
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rd("post_rst_mcycle", 12'hB00, 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
